// File: rtl/vector_mem_sequencer.sv
// Memory-stage access sequencer: turns a scalar or LANES-wide vector load/store
// into single-word beats on the memory port and stalls the pipeline until it finishes.
module vector_mem_sequencer #(
   parameter int LANES = 4,
   parameter int N     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LANES*N-1:0] ALU_result_bus_M,
   input  logic [LANES*N-1:0] write_data_bus_M,
   input  logic               mem_read_M,
   input  logic               mem_write_M,
   input  logic               vector_access_M,
   input  logic [N-1:0]       mem_rdata,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [N-1:0]       mem_wdata,
   output logic               stall_M,
   output logic [LANES*N-1:0] data_bus_M
);

   localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]    state;
   logic [BW-1:0] beat;
   logic [BW-1:0] last;
   logic          is_write;
   logic [31:0]   base;
   logic [N-1:0]  wlanes [LANES];
   logic [N-1:0]  lbuf   [LANES];
   logic [LANES*N-1:0] load_flat;
   logic          op;

   assign op = mem_read_M | mem_write_M;

   // Op type, base address and store data are captured at issue so the beats
   // do not depend on the stalled upstream registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         beat     <= '0;
         last     <= '0;
         is_write <= 1'b0;
         base     <= '0;
         for (int i = 0; i < LANES; i++) begin
            wlanes[i] <= '0;
            lbuf[i]   <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (op) begin
                  state    <= S_ACCESS;
                  beat     <= '0;
                  is_write <= mem_write_M;
                  last     <= vector_access_M ? BW'(LANES - 1) : '0;
                  base     <= {ALU_result_bus_M[31:2], 2'b00};
                  for (int i = 0; i < LANES; i++) begin
                     wlanes[i] <= write_data_bus_M[N*i +: N];
                     lbuf[i]   <= '0;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  if (!is_write) lbuf[beat] <= mem_rdata;
                  if (beat == last) state <= S_DONE;
                  else beat <= beat + BW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               beat  <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      load_flat = '0;
      for (int i = 0; i < LANES; i++) load_flat[N*i +: N] = lbuf[i];
   end

   assign mem_req    = (state == S_ACCESS);
   assign mem_we     = mem_req & is_write;
   assign mem_addr   = base + 32'(beat) * 32'(N / 8);
   assign mem_wdata  = wlanes[beat];
   assign stall_M    = rst_n & (((state == S_IDLE) & op) | (state == S_ACCESS));
   assign data_bus_M = ((state == S_DONE) && !is_write) ? load_flat : ALU_result_bus_M;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: a queue of expected memory beats is
// checked against the port, plus per-cycle stall/request/result checks.
module tb_vector_mem_sequencer;

   localparam int LANES = 4;
   localparam int N     = 32;
   localparam int W     = LANES * N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   ALU_result_bus_M;
   logic [W-1:0]   write_data_bus_M;
   logic           mem_read_M;
   logic           mem_write_M;
   logic           vector_access_M;
   logic [N-1:0]   mem_rdata;
   logic           mem_ready;
   logic           mem_req;
   logic           mem_we;
   logic [31:0]    mem_addr;
   logic [N-1:0]   mem_wdata;
   logic           stall_M;
   logic [W-1:0]   data_bus_M;

   int n_cmp = 0;
   int n_err = 0;
   logic [64:0] exp_q[$];

   always #5 clk = ~clk;

   vector_mem_sequencer #(.LANES(LANES), .N(N)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ALU_result_bus_M (ALU_result_bus_M),
      .write_data_bus_M (write_data_bus_M),
      .mem_read_M       (mem_read_M),
      .mem_write_M      (mem_write_M),
      .vector_access_M  (vector_access_M),
      .mem_rdata        (mem_rdata),
      .mem_ready        (mem_ready),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .stall_M          (stall_M),
      .data_bus_M       (data_bus_M)
   );

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
   endfunction

   function automatic logic [W-1:0] vec_load(input logic [31:0] base, input int nl);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < nl; i++) v[N*i +: N] = rd_val(base + 32'(4 * i));
      return v;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_beats(input logic we, input logic [31:0] base,
                             input logic [W-1:0] wd, input int nl);
      for (int i = 0; i < nl; i++)
         exp_q.push_back({we, base + 32'(4 * i), wd[N*i +: N]});
   endtask

   // One clock cycle: drive ready/rdata, check outputs mid-cycle, then advance.
   task automatic step(input logic rdy, input logic exp_stall, input logic exp_req,
                       input logic [W-1:0] exp_data, input string tag);
      logic [64:0] e;
      @(negedge clk);
      mem_ready = rdy;
      mem_rdata = mem_req ? rd_val(mem_addr) : '0;
      check({tag, "_stall"}, W'(stall_M), W'(exp_stall));
      check({tag, "_req"}, W'(mem_req), W'(exp_req));
      check({tag, "_data"}, data_bus_M, exp_data);
      if (mem_req) begin
         if (exp_q.size() == 0) begin
            check({tag, "_unexpected_beat"}, W'({mem_we, mem_addr, mem_wdata}), '0);
         end else if (rdy) begin
            e = exp_q.pop_front();
            check({tag, "_beat"}, W'({mem_we, mem_addr, mem_wdata}), W'(e));
         end else begin
            check({tag, "_hold"}, W'({mem_we, mem_addr, mem_wdata}), W'(exp_q[0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic vec,
                         input logic [W-1:0] alu, input logic [W-1:0] wd);
      mem_read_M       = rd;
      mem_write_M      = wr;
      vector_access_M  = vec;
      ALU_result_bus_M = alu;
      write_data_bus_M = wd;
   endtask

   initial begin
      logic [W-1:0] alu;
      logic         r;
      int           nb;
      int           cyc;

      rst_n = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      set_op(1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // reset state
      @(negedge clk);
      check("rst_req", W'(mem_req), '0);
      check("rst_we", W'(mem_we), '0);
      check("rst_addr", W'(mem_addr), '0);
      check("rst_wdata", W'(mem_wdata), '0);
      check("rst_stall", W'(stall_M), '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // reset in the middle of a vector load
      alu = {96'h0, 32'h0000_3000};
      set_op(1'b1, 1'b0, 1'b1, alu, '0);
      push_beats(1'b0, 32'h0000_3000, '0, LANES);
      step(1'b1, 1'b1, 1'b0, alu, "rv_idle");
      step(1'b1, 1'b1, 1'b1, alu, "rv_b0");
      step(1'b1, 1'b1, 1'b1, alu, "rv_b1");
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b1, alu, "rv_rstedge");
      step(1'b0, 1'b0, 1'b0, alu, "rv_after");
      exp_q.delete();
      rst_n = 1'b1;

      // fresh vector load after the abort
      alu = {96'h0, 32'h0000_4000};
      set_op(1'b1, 1'b0, 1'b1, alu, '0);
      push_beats(1'b0, 32'h0000_4000, '0, LANES);
      step(1'b1, 1'b1, 1'b0, alu, "fv_idle");
      for (int i = 0; i < LANES; i++) step(1'b1, 1'b1, 1'b1, alu, "fv_acc");
      step(1'b1, 1'b0, 1'b0, vec_load(32'h0000_4000, LANES), "fv_done");

      // scalar load from an unaligned address
      alu = {96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 32'h0000_0103};
      set_op(1'b1, 1'b0, 1'b0, alu, '0);
      push_beats(1'b0, 32'h0000_0100, '0, 1);
      step(1'b1, 1'b1, 1'b0, alu, "sl_idle");
      step(1'b1, 1'b1, 1'b1, alu, "sl_acc");
      step(1'b1, 1'b0, 1'b0, {96'h0, 32'hDEAD_BEEF}, "sl_done");

      // vector store with two wait cycles on beat 2
      alu = {96'h0, 32'h0000_1000};
      set_op(1'b0, 1'b1, 1'b1, alu, {32'h4, 32'h3, 32'h2, 32'h1});
      push_beats(1'b1, 32'h0000_1000, {32'h4, 32'h3, 32'h2, 32'h1}, LANES);
      step(1'b1, 1'b1, 1'b0, alu, "vs_idle");
      step(1'b1, 1'b1, 1'b1, alu, "vs_b0");
      step(1'b1, 1'b1, 1'b1, alu, "vs_b1");
      step(1'b0, 1'b1, 1'b1, alu, "vs_w0");
      step(1'b0, 1'b1, 1'b1, alu, "vs_w1");
      step(1'b1, 1'b1, 1'b1, alu, "vs_b2");
      step(1'b1, 1'b1, 1'b1, alu, "vs_b3");
      step(1'b1, 1'b0, 1'b0, alu, "vs_done");

      // vector load wrapping past the top of the address space
      alu = {96'h0, 32'hFFFF_FFF8};
      set_op(1'b1, 1'b0, 1'b1, alu, '0);
      push_beats(1'b0, 32'hFFFF_FFF8, '0, LANES);
      step(1'b1, 1'b1, 1'b0, alu, "vw_idle");
      for (int i = 0; i < LANES; i++) step(1'b1, 1'b1, 1'b1, alu, "vw_acc");
      step(1'b1, 1'b0, 1'b0, vec_load(32'hFFFF_FFF8, LANES), "vw_done");

      // non-memory op passes straight through
      alu = {96'h0, 32'h0000_1234};
      set_op(1'b0, 1'b0, 1'b0, alu, '0);
      step(1'b1, 1'b0, 1'b0, alu, "alu_pass");

      // read and write both set: write wins
      alu = {96'h1, 32'h0000_2000};
      set_op(1'b1, 1'b1, 1'b0, alu, {96'h0, 32'hCAFE_F00D});
      push_beats(1'b1, 32'h0000_2000, {96'h0, 32'hCAFE_F00D}, 1);
      step(1'b1, 1'b1, 1'b0, alu, "rw_idle");
      step(1'b1, 1'b1, 1'b1, alu, "rw_acc");
      step(1'b1, 1'b0, 1'b0, alu, "rw_done");

      // vector load with random wait states
      alu = {96'h0, 32'h0000_2040};
      set_op(1'b1, 1'b0, 1'b1, alu, '0);
      push_beats(1'b0, 32'h0000_2040, '0, LANES);
      step(1'b1, 1'b1, 1'b0, alu, "vr_idle");
      nb = 0;
      cyc = 0;
      while (nb < LANES && cyc < 40) begin
         r = (cyc >= 8) ? 1'b1 : 1'(Su(0));
         step(r, 1'b1, 1'b1, alu, "vr_acc");
         if (r) nb++;
         cyc++;
      end
      step(1'b1, 1'b0, 1'b0, vec_load(32'h0000_2040, LANES), "vr_done");

      set_op(1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, "idle_end");
      check("beats_left", W'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   function automatic int Su(input int dummy);
      return int'($urandom_range(0, 1)) + dummy;
   endfunction

endmodule
